// File: rtl/div_share_ctl_pkg.sv
// Shared types and constants for the shared-divider controller.
package div_share_ctl_pkg;

  localparam int unsigned DW       = 32;
  localparam int unsigned WDOG_DEF = 40;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK   = 2'd0,
    ERR_DZ   = 2'd1,
    ERR_WDOG = 2'd2
  } err_e;

  typedef struct packed {
    logic [DW-1:0] quot;
    logic [DW-1:0] rem;
    err_e          err;
  } result_t;

endpackage

// File: rtl/div_share_ctl_if.sv
// Request, response and divider-side bundle of the shared-divider controller.
interface div_share_ctl_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
);
  import div_share_ctl_pkg::*;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_x;
  logic [NREQ*DW-1:0] req_y;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [DW-1:0]      resp_quot;
  logic [DW-1:0]      resp_rem;
  logic [1:0]         resp_err;
  logic               flush;
  logic               div_run;
  logic [DW-1:0]      div_x;
  logic [DW-1:0]      div_y;
  logic               div_stall;
  logic [DW-1:0]      div_quot;
  logic [DW-1:0]      div_rem;

  // Controller side
  modport slave (
    input  req_valid, req_x, req_y, resp_ready, flush, div_stall, div_quot, div_rem,
    output req_ready, resp_valid, resp_id, resp_quot, resp_rem, resp_err, div_run, div_x, div_y
  );

  // Requesters, consumer and divider side
  modport master (
    output req_valid, req_x, req_y, resp_ready, flush, div_stall, div_quot, div_rem,
    input  req_ready, resp_valid, resp_id, resp_quot, resp_rem, resp_err, div_run, div_x, div_y
  );

endinterface

// File: rtl/div_share_ctl_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module div_share_ctl_rr_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  int unsigned pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDW'(pos);
      end
    end
  end

endmodule

// File: rtl/div_share_ctl.sv
// Shares one iterative 32-cycle divider among NREQ requesters with round-robin
// arbitration, divide-by-zero bypass, watchdog and a tagged valid/ready response.
module div_share_ctl
  import div_share_ctl_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = 1,
  parameter int unsigned WDOG = WDOG_DEF
) (
  input  logic           clk,
  input  logic           rst,
  div_share_ctl_if.slave bus
);

  localparam int unsigned    CW        = $clog2(WDOG);
  localparam logic [CW-1:0]  WDOG_LAST = CW'(WDOG - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [DW-1:0]  x_q, x_d;
  logic [DW-1:0]  y_q, y_d;
  result_t        res_q, res_d;
  logic           run_q, run_d;
  logic           valid_q, valid_d;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win;
  logic            any;
  logic            accept_c;
  logic [DW-1:0]   x_sel;
  logic [DW-1:0]   y_sel;

  div_share_ctl_rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req  (bus.req_valid),
    .ptr  (ptr_q),
    .grant(grant),
    .idx  (win),
    .any  (any)
  );

  // Grant is only offered while idle and never in a flush cycle
  assign accept_c      = any && (state_q == ST_IDLE) && !bus.flush;
  assign bus.req_ready = accept_c ? grant : '0;

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        x_sel = bus.req_x[i*DW +: DW];
        y_sel = bus.req_y[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    x_d     = x_q;
    y_d     = y_q;
    res_d   = res_q;
    run_d   = 1'b0;
    valid_d = 1'b0;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            ptr_d = (win == LAST_ID) ? '0 : win + IDW'(1);
            id_d  = win;
            x_d   = x_sel;
            y_d   = y_sel;
            if (y_sel == '0) begin
              res_d   = '{quot: {DW{1'b1}}, rem: x_sel, err: ERR_DZ};
              state_d = ST_RESP;
              valid_d = 1'b1;
            end else begin
              cnt_d   = '0;
              state_d = ST_BUSY;
              run_d   = 1'b1;
            end
          end
        end
        ST_BUSY: begin
          cnt_d = cnt_q + CW'(1);
          run_d = 1'b1;
          if (!bus.div_stall) begin
            res_d   = '{quot: bus.div_quot, rem: bus.div_rem, err: ERR_OK};
            state_d = ST_RESP;
            run_d   = 1'b0;
            valid_d = 1'b1;
          end else if (cnt_q == WDOG_LAST) begin
            res_d   = '{quot: '0, rem: '0, err: ERR_WDOG};
            state_d = ST_RESP;
            run_d   = 1'b0;
            valid_d = 1'b1;
          end
        end
        ST_RESP: begin
          valid_d = 1'b1;
          if (bus.resp_ready) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      run_q   <= run_d;
      valid_q <= valid_d;
    end
  end

  assign bus.div_run    = run_q;
  assign bus.div_x      = x_q;
  assign bus.div_y      = y_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_quot  = res_q.quot;
  assign bus.resp_rem   = res_q.rem;
  assign bus.resp_err   = res_q.err;

endmodule

// File: tb/tb_div_share_ctl.sv
// Bench for div_share_ctl: divider stub, transaction-level reference model and
// per-cycle compare, directed scenarios followed by randomized traffic.
module tb_div_share_ctl;
  import div_share_ctl_pkg::*;

  localparam int unsigned NREQ = 2;
  localparam int unsigned IDW  = 1;
  localparam int unsigned WDOG = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_share_ctl_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  div_share_ctl #(.NREQ(NREQ), .IDW(IDW), .WDOG(WDOG)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;
  bit wd_mode = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Floor division for y > 0: remainder always in [0, y)
  function automatic void fdiv(input logic [31:0] x, input logic [31:0] y,
                               output logic [31:0] q, output logic [31:0] r);
    longint sx, sy, qq, rr;
    sx = longint'($signed(x));
    sy = longint'(y);
    if (sy == 0) begin
      q = '0;
      r = '0;
    end else begin
      qq = sx / sy;
      rr = sx % sy;
      if (rr < 0) begin
        qq = qq - 1;
        rr = rr + sy;
      end
      q = qq[31:0];
      r = rr[31:0];
    end
  endfunction

  function automatic logic [31:0] rand_y();
    int unsigned s;
    s = $urandom_range(0, 7);
    if (s == 0) return '0;
    if (s < 4) return 32'($urandom_range(1, 20));
    return $urandom & 32'h7FFF_FFFF;
  endfunction

  // Divider stub: stall low on its 32nd run cycle, garbage on quot/rem otherwise
  int unsigned dcnt;
  logic [31:0] garb;
  logic        done_c;
  logic [31:0] fq, fr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) dcnt <= 0;
    else if (bus.div_run) dcnt <= dcnt + 1;
    else dcnt <= 0;
  end

  always @(posedge clk) garb <= $urandom;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    done_c        = bus.div_run && !wd_mode && (dcnt == 31);
    bus.div_stall = !done_c;
    fdiv(bus.div_x, bus.div_y, fq, fr);
    bus.div_quot  = done_c ? fq : garb;
    bus.div_rem   = done_c ? fr : ~garb;
  end

  // Reference model: one outstanding op with the cycle its response must appear
  typedef struct { int c; int id; } hs_t;
  hs_t hs_log[$];

  bit          outst = 1'b0;
  bit          runs  = 1'b0;
  int          ptr   = 0;
  int          rdy_cyc = 0;
  int          m_id  = 0;
  logic [31:0] m_x, m_y, m_q, m_r;
  logic [1:0]  m_err;

  always @(negedge clk) begin : mon
    logic [NREQ-1:0] er;
    bit ev, erun;
    int w;
    if (!rst) begin
      outst = 1'b0;
      ptr   = 0;
    end else if (chk_en) begin
      er = '0;
      w  = -1;
      if (!outst && !bus.flush)
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && bus.req_valid[(ptr + k) % NREQ]) begin
            w = (ptr + k) % NREQ;
            er[w] = 1'b1;
          end
      ev   = outst && (cyc >= rdy_cyc);
      erun = outst && runs && (cyc < rdy_cyc);
      chk("req_ready", 64'(bus.req_ready), 64'(er));
      chk("resp_valid", 64'(bus.resp_valid), 64'(ev));
      chk("div_run", 64'(bus.div_run), 64'(erun));
      if (erun) begin
        chk("div_x", 64'(bus.div_x), 64'(m_x));
        chk("div_y", 64'(bus.div_y), 64'(m_y));
      end
      if (ev) begin
        chk("resp_id", 64'(bus.resp_id), 64'(m_id));
        chk("resp_quot", 64'(bus.resp_quot), 64'(m_q));
        chk("resp_rem", 64'(bus.resp_rem), 64'(m_r));
        chk("resp_err", 64'(bus.resp_err), 64'(m_err));
      end
      if (bus.flush) begin
        outst = 1'b0;
      end else if (ev && bus.resp_ready) begin
        outst = 1'b0;
        hs_log.push_back('{c: cyc, id: m_id});
      end else if (w >= 0) begin
        m_id  = w;
        m_x   = bus.req_x[w*32 +: 32];
        m_y   = bus.req_y[w*32 +: 32];
        ptr   = (w + 1) % NREQ;
        outst = 1'b1;
        if (m_y == 0) begin
          m_q = '1; m_r = m_x; m_err = 2'd1; rdy_cyc = cyc + 1; runs = 1'b0;
        end else if (wd_mode) begin
          m_q = '0; m_r = '0; m_err = 2'd2; rdy_cyc = cyc + 1 + WDOG; runs = 1'b1;
        end else begin
          fdiv(m_x, m_y, m_q, m_r); m_err = 2'd0; rdy_cyc = cyc + 33; runs = 1'b1;
        end
      end
    end
  end

  task automatic accept_op(input int idx, input logic [31:0] x, input logic [31:0] y,
                           output int t_acc);
    bit got;
    got   = 1'b0;
    t_acc = -1;
    bus.req_valid = '0;
    bus.req_valid[idx] = 1'b1;
    bus.req_x[idx*32 +: 32] = x;
    bus.req_y[idx*32 +: 32] = y;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus.req_ready[idx]) begin
        got   = 1'b1;
        t_acc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    chk("accept_seen", 64'(got), 64'(1));
  endtask

  task automatic wait_resp(input int t_acc, output int lat, output logic [31:0] q,
                           output logic [31:0] r, output logic [1:0] e, output int id);
    lat = -1; q = '0; r = '0; e = '0; id = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = cyc - t_acc;
        q   = bus.resp_quot;
        r   = bus.resp_rem;
        e   = bus.resp_err;
        id  = int'(bus.resp_id);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin : wdog_guard
    #600000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int ta, lat, id, base;
    logic [31:0] q, r;
    logic [1:0]  e;

    bus.req_valid  = '0;
    bus.req_x      = '0;
    bus.req_y      = '0;
    bus.resp_ready = 1'b1;
    bus.flush      = 1'b0;
    rst            = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    chk("rst_div_run", 64'(bus.div_run), 64'(0));
    chk("rst_div_x", 64'(bus.div_x), 64'(0));
    chk("rst_resp_quot", 64'(bus.resp_quot), 64'(0));
    chk("rst_resp_err", 64'(bus.resp_err), 64'(0));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;

    // Single op and negative dividend
    accept_op(0, 32'd100, 32'd7, ta);
    wait_resp(ta, lat, q, r, e, id);
    chk("t1_lat", 64'(lat), 64'(33));
    chk("t1_id", 64'(id), 64'(0));
    chk("t1_quot", 64'(q), 64'(14));
    chk("t1_rem", 64'(r), 64'(2));
    chk("t1_err", 64'(e), 64'(0));

    accept_op(1, 32'hFFFF_FFF9, 32'd2, ta);
    wait_resp(ta, lat, q, r, e, id);
    chk("t2_quot", 64'(q), 64'(32'hFFFF_FFFC));
    chk("t2_rem", 64'(r), 64'(1));
    chk("t2_id", 64'(id), 64'(1));

    // Divide by zero
    accept_op(1, 32'd5, 32'd0, ta);
    wait_resp(ta, lat, q, r, e, id);
    chk("t3_lat", 64'(lat), 64'(1));
    chk("t3_quot", 64'(q), 64'(32'hFFFF_FFFF));
    chk("t3_rem", 64'(r), 64'(5));
    chk("t3_err", 64'(e), 64'(1));

    // Fairness with both requesters continuously valid
    base = hs_log.size();
    bus.req_x = {32'd77, 32'd1000};
    bus.req_y = {32'd5, 32'd3};
    bus.req_valid = '1;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      if (hs_log.size() >= base + 4) break;
    end
    bus.req_valid = '0;
    chk("t4_count", 64'(hs_log.size() >= base + 4), 64'(1));
    if (hs_log.size() >= base + 4) begin
      for (int k = 0; k < 4; k++) chk("t4_id", 64'(hs_log[base+k].id), 64'(k % 2));
      for (int k = 1; k < 4; k++)
        chk("t4_spacing", 64'(hs_log[base+k].c - hs_log[base+k-1].c), 64'(34));
    end
    repeat (40) @(posedge clk);
    #1;

    // Backpressure then flush mid-BUSY
    bus.resp_ready = 1'b0;
    accept_op(0, 32'd1234567, 32'd89, ta);
    wait_resp(ta, lat, q, r, e, id);
    repeat (10) @(posedge clk);
    #1;
    chk("t5_held_valid", 64'(bus.resp_valid), 64'(1));
    chk("t5_held_quot", 64'(bus.resp_quot), 64'(32'd13871));
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    accept_op(0, 32'd500, 32'd9, ta);
    repeat (11) @(posedge clk);
    #1;
    chk("t5_busy_run", 64'(bus.div_run), 64'(1));
    base = hs_log.size();
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("t5_flush_run", 64'(bus.div_run), 64'(0));
    chk("t5_flush_valid", 64'(bus.resp_valid), 64'(0));
    repeat (40) @(posedge clk);
    #1;
    chk("t5_no_resp", 64'(hs_log.size()), 64'(base));
    accept_op(1, 32'd1000, 32'd7, ta);
    wait_resp(ta, lat, q, r, e, id);
    chk("t5_quot", 64'(q), 64'(142));
    chk("t5_rem", 64'(r), 64'(6));

    // Watchdog with stall stuck high
    wd_mode = 1'b1;
    accept_op(0, 32'd50, 32'd3, ta);
    wait_resp(ta, lat, q, r, e, id);
    chk("t6_lat", 64'(lat), 64'(1 + WDOG));
    chk("t6_err", 64'(e), 64'(2));
    chk("t6_quot", 64'(q), 64'(0));
    wd_mode = 1'b0;

    // Asynchronous reset in the middle of an operation
    accept_op(1, 32'd9, 32'd4, ta);
    repeat (10) @(posedge clk);
    #1;
    chk("t6_pre_run", 64'(bus.div_run), 64'(1));
    #1;
    chk_en = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_rst_run", 64'(bus.div_run), 64'(0));
    chk("t6_rst_div_x", 64'(bus.div_x), 64'(0));
    chk("t6_rst_div_y", 64'(bus.div_y), 64'(0));
    chk("t6_rst_valid", 64'(bus.resp_valid), 64'(0));
    chk("t6_rst_id", 64'(bus.resp_id), 64'(0));
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; chk_en = 1'b1;

    // Randomized traffic
    base = hs_log.size();
    for (int t = 0; t < 3000; t++) begin
      bus.req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        bus.req_x[i*32 +: 32] = $urandom;
        bus.req_y[i*32 +: 32] = rand_y();
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      bus.flush      = ($urandom_range(0, 63) == 0);
      @(posedge clk); #1;
    end
    bus.req_valid  = '0;
    bus.flush      = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (80) @(posedge clk);
    #1;
    chk("rand_resp_count", 64'(hs_log.size() - base > 20), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
